// File: rtl/fp_alu_ctrl_pkg.sv
// fp_ctrl_pkg: shared opcode encoding, enable bit positions and FSM state type for the FP ALU sequencer
package fp_ctrl_pkg;
    localparam int FOP_W = 4;
    localparam logic [FOP_W-1:0] FOP_ADD  = 4'd0;
    localparam logic [FOP_W-1:0] FOP_SUB  = 4'd1;
    localparam logic [FOP_W-1:0] FOP_MUL  = 4'd2;
    localparam logic [FOP_W-1:0] FOP_DIV  = 4'd3;
    localparam logic [FOP_W-1:0] FOP_SQRT = 4'd4;
    localparam logic [FOP_W-1:0] FOP_MAX  = 4'd5;
    localparam logic [FOP_W-1:0] FOP_MIN  = 4'd6;
    localparam logic [FOP_W-1:0] FOP_EQ   = 4'd7;
    localparam logic [FOP_W-1:0] FOP_LT   = 4'd8;
    localparam logic [FOP_W-1:0] FOP_LE   = 4'd9;
    localparam int FEN_W    = 10;
    localparam int FEN_ADD  = 9;
    localparam int FEN_SUB  = 8;
    localparam int FEN_MUL  = 7;
    localparam int FEN_DIV  = 6;
    localparam int FEN_SQRT = 5;
    localparam int FEN_MAX  = 4;
    localparam int FEN_MIN  = 3;
    localparam int FEN_EQ   = 2;
    localparam int FEN_LT   = 1;
    localparam int FEN_LE   = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CAPT, ST_RESP} state_t;
    typedef enum logic [1:0] {LAT_ARITH, LAT_DIV, LAT_SQRT} lat_sel_t;
endpackage

// File: rtl/fp_alu_ctrl_if.sv
// fp_alu_ctrl_if: request, ALU and response signals of the FP ALU sequencer
//   slave  : controller side (accepts requests, drives ALU and responses)
//   master : host side (issues requests, models the ALU, consumes responses)
interface fp_alu_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    import fp_ctrl_pkg::*;
    logic                req_valid;
    logic                req_ready;
    logic [FOP_W-1:0]    req_op;
    logic [XLEN-1:0]     req_a;
    logic [XLEN-1:0]     req_b;
    logic [TAG_W-1:0]    req_tag;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [FEN_W-1:0]    alu_en;
    logic [XLEN-1:0]     alu_data_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_data;
    logic [TAG_W-1:0]    rsp_tag;
    logic                rsp_illegal;
    logic                busy;
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, alu_data_out, rsp_ready,
        output req_ready, alu_a, alu_b, alu_en, rsp_valid, rsp_data, rsp_tag, rsp_illegal, busy
    );
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, alu_data_out, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_en, rsp_valid, rsp_data, rsp_tag, rsp_illegal, busy
    );
endinterface

// File: rtl/fp_alu_ctrl_op_decode.sv
// fp_op_decode: maps an FP opcode to its one-hot ALU enable, illegal flag and latency class
//   i_op      : opcode
//   o_en      : one-hot enable, MSB = add, zero for illegal opcodes
//   o_illegal : opcode outside add..le
//   o_lat_sel : which enable-hold latency applies
module fp_op_decode
    import fp_ctrl_pkg::*;
(
    input  logic [FOP_W-1:0] i_op,
    output logic [FEN_W-1:0] o_en,
    output logic             o_illegal,
    output lat_sel_t         o_lat_sel
);
    localparam logic [FEN_W-1:0] ONE = 1;
    assign o_illegal = i_op > FOP_LE;
    assign o_en      = o_illegal ? '0 : ONE << (FOP_LE - i_op);
    assign o_lat_sel = (i_op == FOP_DIV) ? LAT_DIV : (i_op == FOP_SQRT) ? LAT_SQRT : LAT_ARITH;
endmodule

// File: rtl/fp_alu_ctrl.sv
// fp_alu_ctrl: sequences one FP op at a time into the FP ALU and returns its tagged result
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_flush : synchronous abort of the in-flight op, no response issued
//   bus     : request channel, ALU operand/enable/result, response channel, busy
module fp_alu_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ARITH_LAT = 1,
    parameter int DIV_LAT   = 4,
    parameter int SQRT_LAT  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    fp_alu_ctrl_if.slave  bus
);
    localparam int MAX_LAT = (ARITH_LAT > DIV_LAT) ? ((ARITH_LAT > SQRT_LAT) ? ARITH_LAT : SQRT_LAT)
                                                   : ((DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT);
    localparam int CNT_W = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] ARITH_LAST = CNT_W'(ARITH_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] SQRT_LAST  = CNT_W'(SQRT_LAT - 1);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_last;
    logic [FEN_W-1:0]  w_en;
    logic              w_illegal;
    lat_sel_t          w_lat_sel;
    logic [CNT_W-1:0]  w_last;
    fp_op_decode u_dec (
        .i_op      (bus.req_op),
        .o_en      (w_en),
        .o_illegal (w_illegal),
        .o_lat_sel (w_lat_sel)
    );
    // Terminal count for the EXEC counter, latched at accept so the op need not be kept
    assign w_last = (w_lat_sel == LAT_DIV) ? DIV_LAST : (w_lat_sel == LAT_SQRT) ? SQRT_LAST : ARITH_LAST;
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_last          <= '0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_en      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_tag     <= '0;
            bus.rsp_illegal <= 1'b0;
        end else if (i_flush) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            bus.alu_en    <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.req_valid) begin
                    bus.alu_a   <= bus.req_a;
                    bus.alu_b   <= bus.req_b;
                    bus.rsp_tag <= bus.req_tag;
                    r_cnt       <= '0;
                    r_last      <= w_last;
                    if (w_illegal) begin
                        r_state         <= ST_RESP;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_illegal <= 1'b1;
                        bus.rsp_data    <= '0;
                    end else begin
                        r_state    <= ST_EXEC;
                        bus.alu_en <= w_en;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == r_last) begin
                        r_state    <= ST_CAPT;
                        bus.alu_en <= '0;
                    end
                end
                ST_CAPT: begin
                    r_state         <= ST_RESP;
                    bus.rsp_data    <= bus.alu_data_out;
                    bus.rsp_illegal <= 1'b0;
                    bus.rsp_valid   <= 1'b1;
                end
                default: if (bus.rsp_ready) begin
                    r_state       <= ST_IDLE;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_alu_ctrl.sv
// tb_fp_alu_ctrl: directed and randomized checks of fp_alu_ctrl against a behavioural model
module tb_fp_alu_ctrl;
    localparam int XLEN = 32;
    localparam int TAG_W = 5;
    localparam int AL = 1;
    localparam int DL = 4;
    localparam int SL = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [31:0] alu_result = 32'h0;
    int checks = 0;
    int failures = 0;
    fp_alu_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    fp_alu_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .ARITH_LAT(AL), .DIV_LAT(DL), .SQRT_LAT(SL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    // ALU stand-in: registered result while enabled, a distinct value otherwise
    always @(posedge clk) bus.alu_data_out <= (|bus.alu_en) ? alu_result : ~alu_result;
    function automatic int lat_of(input logic [3:0] op);
        return (op == 4'd3) ? DL : (op == 4'd4) ? SL : AL;
    endfunction
    function automatic logic [9:0] en_of(input logic [3:0] op);
        logic [9:0] top;
        top = 10'b1000000000;
        return (op < 4'd10) ? (top >> op) : 10'b0;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input int bp);
        bit legal;
        bit got;
        int n;
        int exp_c;
        legal = op < 4'd10;
        n = lat_of(op);
        exp_c = legal ? n + 1 : 0;
        alu_result = res;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_tag = tag;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // keep offering a different request; it must not be taken while busy
        bus.req_op = 4'($urandom_range(0, 15));
        bus.req_a = ~a;
        bus.req_b = ~b;
        bus.req_tag = ~tag;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c > 0) @(negedge clk);
            chk("alu_en", 32'(bus.alu_en), (legal && c < n) ? 32'(en_of(op)) : 32'd0);
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            chk("alu_a", bus.alu_a, a);
            chk("alu_b", bus.alu_b, b);
            if (bus.rsp_valid) begin
                chk("rsp_latency", 32'(c), 32'(exp_c));
                got = 1'b1;
            end
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        for (int k = 0; k <= bp; k++) begin
            if (k > 0) @(negedge clk);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data", bus.rsp_data, legal ? res : 32'd0);
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
            chk("rsp_illegal", 32'(bus.rsp_illegal), legal ? 32'd0 : 32'd1);
            chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
            chk("alu_en_resp", 32'(bus.alu_en), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = 4'd0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd0, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 0);
        do_op(4'd3, 32'h41200000, 32'h40000000, 5'd9, 32'h40A00000, 0);
        do_op(4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'h55555555, 0);
        do_op(4'd5, 32'hC0000000, 32'h3F000000, 5'd21, 32'h3F000000, 5);
        do_op(4'd9, 32'h00000001, 32'h00000002, 5'd30, 32'h00000001, 2);
        // flush in the second EXEC cycle of a sqrt
        bus.req_valid = 1'b1;
        bus.req_op = 4'd4;
        bus.req_a = 32'h41800000;
        bus.req_tag = 5'd11;
        alu_result = 32'h40800000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("sqrt_en", 32'(bus.alu_en), 32'(10'b0000100000));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_alu_en", 32'(bus.alu_en), 32'd0);
        chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        // flush wins over a request in IDLE
        bus.req_valid = 1'b1;
        bus.req_op = 4'd1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_prio_busy", 32'(bus.busy), 32'd0);
        // asynchronous reset during a mul
        bus.req_valid = 1'b1;
        bus.req_op = 4'd2;
        bus.req_a = 32'h40400000;
        bus.req_b = 32'h40400000;
        bus.req_tag = 5'd17;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mul_en", 32'(bus.alu_en), 32'(10'b0010000000));
        chk("mul_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_alu_en", 32'(bus.alu_en), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        do_op(4'd2, 32'h40400000, 32'h40400000, 5'd17, 32'h41100000, 0);
        for (int i = 0; i < 25; i++)
            do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  $urandom, int'($urandom_range(0, 3)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
